npc_mem_responder: RTL and testbench



---
 rtl/npc_mem_responder_pkg.sv | 17 +
 rtl/npc_mem_store.sv | 35 +++
 rtl/npc_mem_responder.sv | 149 ++++++++++++++
 tb/tb_npc_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_responder_pkg.sv
// rtl/npc_mem_responder_pkg.sv - shared types and constants for the NPC memory responder
package npc_mem_responder_pkg;

    localparam int          CPU_WIDTH         = 64;
    localparam int          CPU_STRB_WIDTH    = CPU_WIDTH / 8;
    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/npc_mem_store.sv
// rtl/npc_mem_store.sv - single-port word array with byte write enables and registered read
module npc_mem_store #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset: contents must survive a responder reset. rdata only moves on a read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/npc_mem_responder.sv
// rtl/npc_mem_responder.sv - valid/ready memory responder with programmable response latency
module npc_mem_responder
    import npc_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = CPU_WIDTH,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter int                    LAT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LAT_WIDTH-1:0]    i_lat,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(DEPTH);

    state_t                 state, state_next;
    logic [LAT_WIDTH-1:0]   cnt, cnt_next;
    logic                   commit;

    logic                   we_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic                   in_range_q;
    logic                   rd_ok;
    logic                   err_q;

    logic [ADDR_WIDTH-1:0]  off, off_word;
    logic                   req_in_range;
    logic [IDX_W-1:0]       req_idx;
    logic                   accept;

    logic                   cur_we, cur_in_range;
    logic [IDX_W-1:0]       cur_idx;
    logic [DATA_WIDTH-1:0]  cur_wdata;
    logic [STRB_W-1:0]      cur_wstrb;
    logic [DATA_WIDTH-1:0]  st_rdata;

    // Lower-bound test first so the subtraction never wraps into the window.
    assign off          = i_req_addr - BASE_ADDR;
    assign off_word     = off >> 3;
    assign req_in_range = (i_req_addr >= BASE_ADDR) && (off_word < ADDR_WIDTH'(DEPTH));
    assign req_idx      = off_word[IDX_W-1:0];

    assign o_req_ready  = rst_n && (state == IDLE);
    assign accept       = i_req_valid && o_req_ready;

    // Zero-latency requests commit on the accept edge, before anything is latched.
    assign cur_we       = (state == IDLE) ? i_req_we     : we_q;
    assign cur_idx      = (state == IDLE) ? req_idx      : idx_q;
    assign cur_wdata    = (state == IDLE) ? i_req_wdata  : wdata_q;
    assign cur_wstrb    = (state == IDLE) ? i_req_wstrb  : wstrb_q;
    assign cur_in_range = (state == IDLE) ? req_in_range : in_range_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next = i_lat;
                    if (i_lat == '0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - LAT_WIDTH'(1);
                if (cnt == LAT_WIDTH'(1)) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            in_range_q <= 1'b0;
            rd_ok      <= 1'b0;
            err_q      <= RSP_OK;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q       <= i_req_we;
                idx_q      <= req_idx;
                wdata_q    <= i_req_wdata;
                wstrb_q    <= i_req_wstrb;
                in_range_q <= req_in_range;
            end
            if (commit) begin
                rd_ok <= !cur_we && cur_in_range;
                err_q <= cur_in_range ? RSP_OK : RSP_ERR;
            end else if (state == RESP && i_rsp_ready) begin
                rd_ok <= 1'b0;
                err_q <= RSP_OK;
            end
        end
    end

    npc_mem_store #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_store (
        .clk   (clk),
        .en    (commit && cur_in_range),
        .we    (cur_we),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .rdata (st_rdata)
    );

    assign o_rsp_valid = (state == RESP);
    assign o_rsp_rdata = rd_ok ? st_rdata : '0;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_npc_mem_responder.sv
// tb/tb_npc_mem_responder.sv - directed self-checking bench for npc_mem_responder
module tb_npc_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lat = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [int];

    always #5 clk = ~clk;

    npc_mem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lat       (lat),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic drive(input logic we, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic [3:0] l);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; lat = l;
    endtask

    // Returns just after the accept edge; request inputs and i_lat are then scrambled.
    task automatic send(input logic we, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [3:0] l);
        int n = 0;
        drive(we, a, d, s, l);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'($urandom);
        lat       = 4'($urandom);
    endtask

    task automatic await_rsp(input int l, input logic [63:0] d, input logic e, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 40);
        check({tag, "_latency"}, 64'(k), 64'(l + 1));
        check({tag, "_rdata"}, rsp_rdata, d);
        check({tag, "_err"}, 64'(rsp_err), 64'(e));
        check({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
    endtask

    task automatic hold(input int n, input logic [63:0] d, input logic e, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, d);
            check({tag, "_hold_err"}, 64'(rsp_err), 64'(e));
            check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
    endtask

    task automatic retire(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_retired_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_retired_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic txn(input logic we, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [3:0] l, input int h,
                       input logic [63:0] exp_d, input logic exp_e, input string tag);
        send(we, a, d, s, l);
        await_rsp(int'(l), exp_d, exp_e, tag);
        hold(h, exp_d, exp_e, tag);
        retire(tag);
    endtask

    initial begin
        logic [63:0] a, d;
        logic [7:0]  s;
        logic [3:0]  l;
        int          idx;

        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 64'(req_ready), 64'd1);

        txn(1'b1, BASE, 64'h1122334455667788, 8'hFF, 4'd0, 0, 64'd0, 1'b0, "preload_w0");
        txn(1'b1, BASE + 8, 64'd0, 8'hFF, 4'd2, 0, 64'd0, 1'b0, "clear_w1");
        txn(1'b0, BASE, 64'd0, 8'h00, 4'd0, 0, 64'h1122334455667788, 1'b0, "read_w0_lat0");
        txn(1'b1, BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'b0000_1111, 4'd3, 0, 64'd0, 1'b0, "strb_write_w1");
        txn(1'b0, BASE + 8, 64'd0, 8'h00, 4'd1, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, "read_w1");

        send(1'b0, BASE, 64'd0, 8'h00, 4'd2);
        await_rsp(2, 64'h1122334455667788, 1'b0, "bp");
        drive(1'b0, BASE + 8, 64'd0, 8'h00, 4'd0);
        hold(5, 64'h1122334455667788, 1'b0, "bp");
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_retire_valid", 64'(rsp_valid), 64'd0);
        check("bp_retire_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_next_accepted", 64'(rsp_valid), 64'd1);
        check("bp_next_rdata", rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        retire("bp_next");

        txn(1'b1, BASE + 16, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 4'd1, 0, 64'd0, 1'b0, "write_w2");
        txn(1'b1, BASE + 16, 64'h0123_4567_89AB_CDEF, 8'h00, 4'd0, 0, 64'd0, 1'b0, "write_w2_strb0");
        txn(1'b1, BASE + 64'h11, 64'h1234_5678_0000_0000, 8'hF0, 4'd0, 0, 64'd0, 1'b0, "write_w2_hi");
        txn(1'b0, BASE + 16, 64'd0, 8'h00, 4'd2, 0, 64'h1234_5678_A5A5_A5A5, 1'b0, "read_w2");
        txn(1'b1, BASE + 64'h1FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 4'd0, 0, 64'd0, 1'b0, "write_last");
        txn(1'b0, BASE + 64'h1FF8, 64'd0, 8'h00, 4'd5, 0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, "read_last");

        txn(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 4'd0, 0, 64'd0, 1'b1, "oor_below");
        txn(1'b0, BASE + 64'h2000, 64'd0, 8'h00, 4'd4, 2, 64'd0, 1'b1, "oor_end");
        txn(1'b1, BASE + 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd0, 0, 64'd0, 1'b1, "oor_write");
        txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd1, 0, 64'd0, 1'b1, "oor_top");
        txn(1'b0, BASE, 64'd0, 8'h00, 4'd0, 0, 64'h1122334455667788, 1'b0, "oor_keep_w0");
        txn(1'b0, BASE + 8, 64'd0, 8'h00, 4'd0, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, "oor_keep_w1");
        txn(1'b0, BASE + 64'h1FF8, 64'd0, 8'h00, 4'd0, 0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, "oor_keep_last");

        send(1'b1, BASE + 16, 64'd0, 8'hFF, 4'd7);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready_after", 64'(req_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        txn(1'b0, BASE + 16, 64'd0, 8'h00, 4'd0, 0, 64'h1234_5678_A5A5_A5A5, 1'b0, "mid_rst_keep_w2");

        for (int i = 0; i < 16; i++) begin
            idx = int'($urandom_range(3, 1022));
            a   = BASE + 64'(idx) * 8;
            d   = {$urandom, $urandom};
            s   = model.exists(idx) ? 8'($urandom) : 8'hFF;
            l   = 4'($urandom_range(0, 15));
            txn(1'b1, a, d, s, l, int'($urandom_range(0, 3)), 64'd0, 1'b0, "stream_w");
            model[idx] = merge(model.exists(idx) ? model[idx] : 64'd0, d, s);
            l   = 4'($urandom_range(0, 15));
            txn(1'b0, a, 64'd0, 8'h00, l, int'($urandom_range(0, 3)), model[idx], 1'b0, "stream_r");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
